// File: rtl/sprite_rom_arbiter.sv
// Purpose : shares one synchronous sprite ROM read port between the display pixel
//           fetch (port 0) and auxiliary game logic (port 1). During active video
//           port 0 has priority and port 1 has a starvation guard. During blanking
//           the two ports are served round-robin. Each response goes back to the
//           port that issued the read.
// Latency : the grant is combinational in the request cycle. The response appears
//           ROM_LAT cycles later, and rsp_data adds no further latency.
// Backpr. : reqN_ready is the grant and allows at most one transfer per cycle. A
//           request that loses holds its valid and address until it is granted.
//
// Ports   : vga_clk/reset (asynchronous, active-high), display_active,
//           req0_valid/req0_addr/req0_ready, req1_valid/req1_addr/req1_ready,
//           rom_address/rom_rd/rom_q, and rsp0_valid/rsp1_valid/rsp_data.
// Option  : defining SPRITE_ARB_STATS_EN adds the stats_clear input and the
//           grant0_count, grant1_count and max_wait_seen outputs.
module sprite_rom_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 4,
    parameter int ROM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              display_active,
`ifdef SPRITE_ARB_STATS_EN
    input  logic              stats_clear,
    output logic [15:0]       grant0_count,
    output logic [15:0]       grant1_count,
    output logic [7:0]        max_wait_seen,
`endif
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_rd,
    input  logic [DATA_W-1:0] rom_q,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_data
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0]         wait_cnt;    // consecutive stalled cycles of a pending port-1 request
    logic               last_grant;  // port id of the most recent grant
    logic [ADDR_W-1:0]  addr_hold;   // address of the most recent grant
    logic [ROM_LAT-1:0] pipe_vld;    // response slots in flight; index 0 is the newest
    logic [ROM_LAT-1:0] pipe_id;
    logic               gnt0;
    logic               gnt1;

    // The arbiter issues at most one grant per cycle. While reset is high it issues
    // none, so neither ready is asserted during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (display_active) begin
                if (req1_valid && wait_cnt == MAX_WAIT_C)
                    gnt1 = 1'b1;
                else if (req0_valid)
                    gnt0 = 1'b1;
                else if (req1_valid)
                    gnt1 = 1'b1;
            end else begin
                if (req0_valid && req1_valid) begin
                    // On a tie, the port that was not granted last wins.
                    if (last_grant)
                        gnt0 = 1'b1;
                    else
                        gnt1 = 1'b1;
                end else if (req0_valid) begin
                    gnt0 = 1'b1;
                end else if (req1_valid) begin
                    gnt1 = 1'b1;
                end
            end
        end
    end

    assign req0_ready  = gnt0;
    assign req1_ready  = gnt1;
    assign rom_rd      = gnt0 | gnt1;
    assign rom_address = gnt0 ? req0_addr : (gnt1 ? req1_addr : addr_hold);

    // The oldest pipeline slot lines up with rom_q for the read it tracks.
    assign rsp0_valid = pipe_vld[ROM_LAT-1] & ~pipe_id[ROM_LAT-1];
    assign rsp1_valid = pipe_vld[ROM_LAT-1] &  pipe_id[ROM_LAT-1];
    // rsp_data is forced to zero when no response is valid, so reset shows 0.
    assign rsp_data   = pipe_vld[ROM_LAT-1] ? rom_q : '0;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            wait_cnt   <= 8'd0;
            last_grant <= 1'b1;
            addr_hold  <= '0;
            pipe_vld   <= '0;
            pipe_id    <= '0;
        end else begin
            if (gnt1 || !req1_valid)
                wait_cnt <= 8'd0;
            else if (wait_cnt < MAX_WAIT_C)
                wait_cnt <= wait_cnt + 8'd1;

            if (gnt0 || gnt1) begin
                last_grant <= gnt1;
                addr_hold  <= rom_address;
            end

            // An idle cycle shifts an invalid slot into the pipeline.
            for (int i = ROM_LAT - 1; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
            pipe_vld[0] <= gnt0 | gnt1;
            pipe_id[0]  <= gnt1;
        end
    end

`ifdef SPRITE_ARB_STATS_EN
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            grant0_count  <= 16'd0;
            grant1_count  <= 16'd0;
            max_wait_seen <= 8'd0;
        end else if (stats_clear) begin
            grant0_count  <= 16'd0;
            grant1_count  <= 16'd0;
            max_wait_seen <= 8'd0;
        end else begin
            if (gnt0 && grant0_count != 16'hFFFF)
                grant0_count <= grant0_count + 16'd1;
            if (gnt1 && grant1_count != 16'hFFFF)
                grant1_count <= grant1_count + 16'd1;
            if (wait_cnt > max_wait_seen)
                max_wait_seen <= wait_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Purpose : self-checking bench for sprite_rom_arbiter, covering directed cases and
//           randomized traffic compared against a reference model.
// Latency : the model expects each response LAT cycles after its grant.
// Backpr. : held requests are re-presented until they are granted.
module tb_sprite_rom_arbiter;

    localparam int AW  = 13;
    localparam int DW  = 4;
    localparam int LAT = 2;
    localparam int MW  = 4;

    logic          vga_clk;
    logic          reset;
    logic          display_active;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic          req1_ready;
    logic [AW-1:0] rom_address;
    logic          rom_rd;
    logic [DW-1:0] rom_q;
    logic          rsp0_valid;
    logic          rsp1_valid;
    logic [DW-1:0] rsp_data;
`ifdef SPRITE_ARB_STATS_EN
    logic          stats_clear;
    logic [15:0]   grant0_count;
    logic [15:0]   grant1_count;
    logic [7:0]    max_wait_seen;
`endif

    sprite_rom_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT), .MAX_WAIT(MW)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .display_active(display_active),
`ifdef SPRITE_ARB_STATS_EN
        .stats_clear(stats_clear), .grant0_count(grant0_count),
        .grant1_count(grant1_count), .max_wait_seen(max_wait_seen),
`endif
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rom_address(rom_address), .rom_rd(rom_rd), .rom_q(rom_q),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Sprite ROM model: the word stored at an address is addr[3:0], and it is
    // returned LAT cycles after the address is presented.
    logic [DW-1:0] rom_pipe [LAT];
    always @(posedge vga_clk) begin
        rom_pipe[0] <= rom_address[3:0];
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = rom_pipe[LAT-1];

    typedef struct {
        int         due;
        bit         id;
        logic [3:0] data;
    } rsp_t;

    rsp_t          expq[$];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            m_run;      // number of consecutive cycles port 1 has been refused
    int            m_last;     // port that was granted most recently
    logic [AW-1:0] m_hold;
    int            n_rd;
    int            n_rsp;
    logic          obs_r1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit da, input bit v0, input logic [AW-1:0] a0,
                         input bit v1, input logic [AW-1:0] a1);
        display_active = da;
        req0_valid     = v0;
        req0_addr      = a0;
        req1_valid     = v1;
        req1_addr      = a1;
    endtask

    // This task runs one checked cycle. It is entered 1 time unit after a rising
    // edge, compares the outputs at the falling edge, then advances the model.
    task automatic cycle();
        int            eg;
        logic [AW-1:0] ea;
        bit            e0, e1;
        logic [3:0]    ed;
        rsp_t          r;
        @(negedge vga_clk);
        eg = -1;
        if (display_active) begin
            if (req1_valid && m_run == MW) eg = 1;
            else if (req0_valid)           eg = 0;
            else if (req1_valid)           eg = 1;
        end else begin
            if (req0_valid && req1_valid)  eg = (m_last == 1) ? 0 : 1;
            else if (req0_valid)           eg = 0;
            else if (req1_valid)           eg = 1;
        end
        ea = (eg == 0) ? req0_addr : ((eg == 1) ? req1_addr : m_hold);
        check("req0_ready", req0_ready, eg == 0);
        check("req1_ready", req1_ready, eg == 1);
        check("rom_rd", rom_rd, eg >= 0);
        check("rom_address", rom_address, ea);
        e0 = 1'b0; e1 = 1'b0; ed = '0;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e0 = (expq[0].id == 1'b0);
            e1 = (expq[0].id == 1'b1);
            ed = expq[0].data;
            void'(expq.pop_front());
        end
        check("rsp0_valid", rsp0_valid, e0);
        check("rsp1_valid", rsp1_valid, e1);
        if (e0 || e1) check("rsp_data", rsp_data, ed);
        obs_r1 = req1_ready;
        n_rd  += int'(rom_rd);
        n_rsp += int'(rsp0_valid) + int'(rsp1_valid);
        if (eg >= 0) begin
            m_last = eg;
            m_hold = ea;
            r.due  = cyc + LAT;
            r.id   = eg[0];
            r.data = ea[3:0];
            expq.push_back(r);
        end
        if (req1_valid && eg != 1) m_run = (m_run < MW) ? m_run + 1 : MW;
        else                       m_run = 0;
        @(posedge vga_clk);
        #1;
        cyc++;
    endtask

    // This task pulses reset for one cycle, with requests possibly still valid.
    task automatic do_reset();
        reset = 1'b1;
        @(negedge vga_clk);
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_req1_ready", req1_ready, 1'b0);
        check("rst_rom_rd", rom_rd, 1'b0);
        check("rst_rom_address", rom_address, '0);
        check("rst_rsp0_valid", rsp0_valid, 1'b0);
        check("rst_rsp1_valid", rsp1_valid, 1'b0);
        check("rst_rsp_data", rsp_data, '0);
        expq.delete();
        m_run  = 0;
        m_last = 1;
        m_hold = '0;
        @(posedge vga_clk);
        #1;
        reset = 1'b0;
        cyc++;
    endtask

    task automatic idle(input int n);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, '0);
`ifdef SPRITE_ARB_STATS_EN
        stats_clear = 1'b0;
`endif
        @(posedge vga_clk);
        #1;
        do_reset();

        // Active video with both ports requesting: four port-0 grants, then one
        // forced port-1 grant, and the pattern repeats.
        drive(1'b1, 1'b1, 13'd100, 1'b1, 13'd201);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("t2_port1_pattern", obs_r1, (i % 5) == 4);
        end
        idle(LAT + 1);

        // Blanking with both ports requesting: grants alternate 0,1,0,1 and the
        // returned data alternates A and 4.
        do_reset();
        drive(1'b0, 1'b1, 13'd10, 1'b1, 13'd20);
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("t3_alternate", obs_r1, (i % 2) == 1);
        end
        idle(LAT + 1);

        // Only port 1 requests, at the last sprite word.
        drive(1'b1, 1'b0, '0, 1'b1, 13'd4624);
        cycle();
        check("t4_ready_same_cycle", obs_r1, 1'b1);
        idle(LAT + 2);
        check("t4_addr_hold", rom_address, 13'd4624);

        // display_active drops during contention after a port-0 grant.
        do_reset();
        n_rd = 0;
        n_rsp = 0;
        drive(1'b1, 1'b1, 13'd7, 1'b1, 13'd9);
        cycle();
        drive(1'b0, 1'b1, 13'd7, 1'b1, 13'd9);
        cycle();
        check("t5_port1_same_cycle", obs_r1, 1'b1);
        idle(LAT + 1);
        check("t5_grants_eq_rsps", n_rsp, n_rd);

        // Randomized traffic.
        n_rd = 0;
        n_rsp = 0;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  AW'($urandom_range(0, 4624)), 1'($urandom_range(0, 2) != 0),
                  AW'($urandom_range(0, 4624)));
            cycle();
        end
        idle(LAT + 1);
        check("rand_grants_eq_rsps", n_rsp, n_rd);

        // Reset pulse while reads are in flight. Nothing is replayed afterwards,
        // and the first tie after release goes to port 0.
        drive(1'b0, 1'b1, 13'd33, 1'b1, 13'd66);
        cycle();
        cycle();
        do_reset();
        idle(2);
        drive(1'b0, 1'b1, 13'd3, 1'b1, 13'd5);
        cycle();
        check("t1_first_tie_port0", obs_r1, 1'b0);
        idle(LAT + 1);

`ifdef SPRITE_ARB_STATS_EN
        do_reset();
        check("st_rst_g0", grant0_count, 16'd0);
        drive(1'b1, 1'b1, 13'd1, 1'b1, 13'd2);
        for (int i = 0; i < 6; i++) begin
            @(posedge vga_clk);
            #1;
        end
        drive(1'b1, 1'b1, 13'd1, 1'b0, 13'd2);
        for (int i = 0; i < 70000; i++) begin
            @(posedge vga_clk);
            #1;
        end
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        check("st_g0_sat", grant0_count, 16'hFFFF);
        check("st_g1", grant1_count, 16'd1);
        check("st_max_wait", max_wait_seen, 8'(MW));
        stats_clear = 1'b1;
        @(posedge vga_clk);
        #1;
        stats_clear = 1'b0;
        check("st_clr_g0", grant0_count, 16'd0);
        check("st_clr_g1", grant1_count, 16'd0);
        check("st_clr_mw", max_wait_seen, 8'd0);
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
Shares one synchronous sprite ROM read port between two requesters. Port 0 is the display pixel fetch and port 1 is auxiliary game logic, such as collision lookup or a HUD overlay. Port 0 has priority during visible video, with a starvation guard for port 1; during blanking, the two ports are served round-robin. Responses are returned to the originating port after a fixed ROM latency, so palette and pixel logic downstream need not know the ROM is shared.

Parameters:
ADDR_W, 13, ROM address width
DATA_W, 4, ROM word width (palette index)
ROM_LAT, 1, ROM read latency in vga_clk cycles (1..4)
MAX_WAIT, 4, consecutive stalled cycles of a pending port-1 request before it is force-granted during active video (1..255)

Ports:
vga_clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
display_active  in  1  1 = visible region; port 0 has priority
req0_valid  in  1  port 0 read request
req0_addr  in  ADDR_W  port 0 address
req0_ready  out  1  port 0 granted this cycle
req1_valid  in  1  port 1 read request
req1_addr  in  ADDR_W  port 1 address
req1_ready  out  1  port 1 granted this cycle
rom_address  out  ADDR_W  address to ROM
rom_rd  out  1  ROM read strobe (1 on any grant)
rom_q  in  DATA_W  ROM data, valid ROM_LAT cycles after rom_rd
rsp0_valid  out  1  rsp_data belongs to port 0
rsp1_valid  out  1  rsp_data belongs to port 1
rsp_data  out  DATA_W  returned ROM word

Behaviour:
- Transfer rule: a transfer occurs when reqN_valid && reqN_ready. At most one grant per cycle. reqN_ready is combinational from the current-cycle valids and state, and is never 1 while reqN_valid=0.
- Grant rule when display_active=1:
  - port 1 wins if req1_valid && wait_cnt==MAX_WAIT;
  - otherwise port 0 wins if req0_valid;
  - otherwise port 1 wins if req1_valid.
- Grant rule when display_active=0: round-robin. On a tie, the port not granted last wins. last_grant is updated only on a grant.
- wait_cnt (8 bit):
  - increments when req1_valid && !req1_ready, saturating at MAX_WAIT;
  - clears to 0 on a port-1 grant or when req1_valid=0.
- ROM drive:
  - rom_address is the granted port's address on a grant cycle; otherwise it holds the last granted address (hold register).
  - rom_rd=1 exactly on grant cycles.
- Response pipeline: a shift register of {valid, id} with depth ROM_LAT. rspN_valid is asserted exactly ROM_LAT cycles after the port-N grant. rsp_data=rom_q is registered-through, with zero extra latency beyond ROM_LAT. rsp0_valid and rsp1_valid are never both 1.
- Back-to-back grants are fully pipelined: throughput is 1 read per cycle.
- display_active may toggle in any cycle. The new priority rule applies in that same cycle. In-flight responses are unaffected.
- Reset (async, any time):
  - req0_ready=0, req1_ready=0 while reset is high;
  - rom_rd=0, rom_address=0, rsp0_valid=0, rsp1_valid=0, rsp_data=0;
  - wait_cnt=0, last_grant=1 (port 0 wins the first tie);
  - in-flight responses are discarded, not replayed.
- No request: no grant, rom_rd=0, and the pipeline shifts in an invalid slot.

Optional Feature:
- Macro: SPRITE_ARB_STATS_EN.
- When defined:
  - adds outputs grant0_count[15:0], grant1_count[15:0] and max_wait_seen[7:0], all reset to 0;
  - grant counters increment per grant and saturate at 16'hFFFF;
  - max_wait_seen records the peak wait_cnt;
  - adds input stats_clear, a synchronous clear of all three.
- When undefined: none of these ports or registers exist, and arbitration behaviour is identical.

Test Plan:
1. Reset mid-stream: grants in flight with ROM_LAT=2, reset pulsed for 1 cycle -> the next 2 cycles show rsp0_valid=0 and rsp1_valid=0, rom_address=0, and the first tie after release goes to port 0.
2. display_active=1 with req0_valid held high and req1_valid held high (MAX_WAIT=4) -> grants are port 0 ×4, then port 1 ×1, then port 0 ×4; wait_cnt returns to 0 after the port-1 grant.
3. display_active=0 with both ports valid continuously -> grants alternate 0,1,0,1…. With req0_addr=13'd10, req1_addr=13'd20 and ROM word = addr[3:0], rsp alternates rsp0 data 4'hA / rsp1 data 4'h4 (20 = 0x14, so addr[3:0]=4) with 1-cycle latency (ROM_LAT=1).
4. Only req1_valid with address 13'd4624 (last word, 185×25−1) -> req1_ready=1 in the same cycle, rom_rd=1, rsp1_valid=1 one cycle later, and rom_address holds 4624 once idle.
5. display_active drops during contention, in the cycle where port 0 was granted last -> port 1 is granted in that same cycle; no response is lost or duplicated (count grants == count rsp valids).
6. With SPRITE_ARB_STATS_EN defined, 70000 port-0 grants -> grant0_count=16'hFFFF; stats_clear -> all counters 0 next cycle.
